// File: rtl/rvsteel_button_controller.sv
// Turns raw, bouncy reset/halt push-buttons into clean soc_reset/soc_halt for rvsteel_soc.
// Each button is synchronized and debounced; reset is stretched by a hold-off sequencer.
module rvsteel_button_controller #(
    parameter int DEBOUNCE_CYCLES   = 120000,
    parameter int RESET_HOLD_CYCLES = 16,
    parameter int HALT_TOGGLE_MODE  = 0
) (
    input  logic clock,
    input  logic reset,
    input  logic reset_button,
    input  logic halt_button,
    output logic soc_reset,
    output logic soc_halt
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_RUN
    } state_t;

    logic          reset_s1, reset_s2, halt_s1, halt_s2;
    logic [DW-1:0] reset_cnt, halt_cnt;
    logic          reset_stable, halt_stable;
    logic          halt_prev, halt_latch;
    state_t        state, next_state;
    logic [HW-1:0] hold_cnt, next_hold_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            reset_s1 <= 1'b0;
            reset_s2 <= 1'b0;
            halt_s1  <= 1'b0;
            halt_s2  <= 1'b0;
        end else begin
            reset_s1 <= reset_button;
            reset_s2 <= reset_s1;
            halt_s1  <= halt_button;
            halt_s2  <= halt_s1;
        end
    end

    // Reset button powers up as "pressed" so the SoC is held until the debouncer sees a release.
    always_ff @(posedge clock) begin
        if (reset) begin
            reset_stable <= 1'b1;
            reset_cnt    <= '0;
        end else if (reset_s2 == reset_stable) begin
            reset_cnt <= '0;
        end else if (reset_cnt == DEB_LAST) begin
            reset_stable <= reset_s2;
            reset_cnt    <= '0;
        end else begin
            reset_cnt <= reset_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            halt_stable <= 1'b0;
            halt_cnt    <= '0;
        end else if (halt_s2 == halt_stable) begin
            halt_cnt <= '0;
        end else if (halt_cnt == DEB_LAST) begin
            halt_stable <= halt_s2;
            halt_cnt    <= '0;
        end else begin
            halt_cnt <= halt_cnt + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= ST_ASSERT;
            hold_cnt <= '0;
        end else begin
            state    <= next_state;
            hold_cnt <= next_hold_cnt;
        end
    end

    always_comb begin
        next_state    = state;
        next_hold_cnt = hold_cnt;
        case (state)
            ST_ASSERT: begin
                if (!reset_stable) begin
                    next_state    = ST_HOLD;
                    next_hold_cnt = '0;
                end
            end
            ST_HOLD: begin
                if (reset_stable) begin
                    next_state    = ST_ASSERT;
                    next_hold_cnt = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    next_state = ST_RUN;
                end else begin
                    next_hold_cnt = hold_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (reset_stable) next_state = ST_ASSERT;
            end
            default: next_state = ST_ASSERT;
        endcase
    end

    assign soc_reset = (state != ST_RUN);

    // Toggle presses landing while the SoC is in reset are dropped, not queued.
    always_ff @(posedge clock) begin
        if (reset) begin
            halt_prev  <= 1'b0;
            halt_latch <= 1'b0;
            soc_halt   <= 1'b0;
        end else begin
            halt_prev <= halt_stable;
            if (soc_reset)
                halt_latch <= 1'b0;
            else if (halt_stable && !halt_prev)
                halt_latch <= ~halt_latch;
            soc_halt <= (HALT_TOGGLE_MODE != 0) ? halt_latch : halt_stable;
        end
    end

endmodule

// File: tb/tb_rvsteel_button_controller.sv
// Directed bench: level-halt, toggle-halt and long-hold instances share the button inputs.
module tb_rvsteel_button_controller;

    logic clock;
    logic reset;
    logic reset_button;
    logic halt_button;
    logic soc_reset0, soc_halt0;
    logic soc_reset1, soc_halt1;
    logic soc_reset2, soc_halt2;

    int checks = 0;
    int errors = 0;

    rvsteel_button_controller #(
        .DEBOUNCE_CYCLES(4), .RESET_HOLD_CYCLES(3), .HALT_TOGGLE_MODE(0)
    ) dut0 (
        .clock(clock), .reset(reset), .reset_button(reset_button),
        .halt_button(halt_button), .soc_reset(soc_reset0), .soc_halt(soc_halt0)
    );

    rvsteel_button_controller #(
        .DEBOUNCE_CYCLES(4), .RESET_HOLD_CYCLES(3), .HALT_TOGGLE_MODE(1)
    ) dut1 (
        .clock(clock), .reset(reset), .reset_button(reset_button),
        .halt_button(halt_button), .soc_reset(soc_reset1), .soc_halt(soc_halt1)
    );

    // Longer hold window so a re-press can register while still in HOLD.
    rvsteel_button_controller #(
        .DEBOUNCE_CYCLES(4), .RESET_HOLD_CYCLES(10), .HALT_TOGGLE_MODE(0)
    ) dut2 (
        .clock(clock), .reset(reset), .reset_button(reset_button),
        .halt_button(halt_button), .soc_reset(soc_reset2), .soc_halt(soc_halt2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset        = 1'b1;
        reset_button = 1'b0;
        halt_button  = 1'b0;
        step(5);
        reset = 1'b0;
        step(8);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        reset_button = 1'b0;
        halt_button  = 1'b0;
        step(5);
        checks++;
        if (soc_reset0 !== 1'b1 || soc_halt0 !== 1'b0 || soc_halt1 !== 1'b0) begin
            errors++;
            $display("FAIL reset_state soc_reset=%b soc_halt0=%b soc_halt1=%b exp 1 0 0",
                     soc_reset0, soc_halt0, soc_halt1);
        end
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            checks++;
            if (soc_reset0 !== (i < 8) || soc_reset1 !== (i < 8)) begin
                errors++;
                $display("FAIL powerup_reset edge %0d got %b/%b exp %b",
                         i, soc_reset0, soc_reset1, (i < 8));
            end
            checks++;
            if (soc_halt0 !== 1'b0 || soc_halt1 !== 1'b0) begin
                errors++;
                $display("FAIL powerup_halt edge %0d got %b/%b exp 0", i, soc_halt0, soc_halt1);
            end
        end
    endtask

    task automatic test_glitch();
        apply_reset();
        halt_button = 1'b1;
        step(3);
        halt_button = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            checks++;
            if (soc_halt0 !== 1'b0 || soc_halt1 !== 1'b0) begin
                errors++;
                $display("FAIL glitch_ignored edge %0d got %b/%b exp 0", i, soc_halt0, soc_halt1);
            end
        end
        halt_button = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            checks++;
            if (soc_halt0 !== (i >= 7) || soc_halt2 !== (i >= 7)) begin
                errors++;
                $display("FAIL level_halt_rise edge %0d got %b/%b exp %b",
                         i, soc_halt0, soc_halt2, (i >= 7));
            end
            checks++;
            if (soc_halt1 !== (i >= 8)) begin
                errors++;
                $display("FAIL toggle_halt_rise edge %0d got %b exp %b", i, soc_halt1, (i >= 8));
            end
        end
        halt_button = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            checks++;
            if (soc_halt0 !== (i < 7)) begin
                errors++;
                $display("FAIL level_halt_fall edge %0d got %b exp %b", i, soc_halt0, (i < 7));
            end
            checks++;
            if (soc_halt1 !== 1'b1) begin
                errors++;
                $display("FAIL toggle_halt_keep edge %0d got %b exp 1", i, soc_halt1);
            end
        end
    endtask

    task automatic test_reset_press();
        apply_reset();
        reset_button = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            checks++;
            if (soc_reset0 !== (i >= 7)) begin
                errors++;
                $display("FAIL press_rise edge %0d got %b exp %b", i, soc_reset0, (i >= 7));
            end
        end
        reset_button = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step(1);
            checks++;
            if (soc_reset0 !== (i < 10)) begin
                errors++;
                $display("FAIL press_fall edge %0d got %b exp %b", i, soc_reset0, (i < 10));
            end
        end
    endtask

    task automatic test_repress_hold();
        apply_reset();
        step(7);
        checks++;
        if (soc_reset2 !== 1'b0) begin
            errors++;
            $display("FAIL repress_run_start got %b exp 0", soc_reset2);
        end
        reset_button = 1'b1;
        step(10);
        reset_button = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            checks++;
            if (soc_reset2 !== 1'b1) begin
                errors++;
                $display("FAIL repress_release edge %0d got %b exp 1", i, soc_reset2);
            end
        end
        reset_button = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            checks++;
            if (soc_reset2 !== 1'b1) begin
                errors++;
                $display("FAIL repress_held edge %0d got %b exp 1", i, soc_reset2);
            end
        end
        reset_button = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            checks++;
            if (soc_reset2 !== (i < 17)) begin
                errors++;
                $display("FAIL repress_full_hold edge %0d got %b exp %b", i, soc_reset2, (i < 17));
            end
        end
    endtask

    task automatic test_toggle();
        apply_reset();
        for (int p = 0; p < 2; p++) begin
            halt_button = 1'b1;
            for (int i = 1; i <= 10; i++) begin
                step(1);
                checks++;
                if (soc_halt1 !== ((p == 0) ? (i >= 8) : (i < 8))) begin
                    errors++;
                    $display("FAIL toggle_press%0d edge %0d got %b exp %b",
                             p, i, soc_halt1, ((p == 0) ? (i >= 8) : (i < 8)));
                end
            end
            halt_button = 1'b0;
            step(20);
            checks++;
            if (soc_halt1 !== (p == 0)) begin
                errors++;
                $display("FAIL toggle_settle%0d got %b exp %b", p, soc_halt1, (p == 0));
            end
        end
        reset_button = 1'b1;
        step(7);
        checks++;
        if (soc_reset1 !== 1'b1) begin
            errors++;
            $display("FAIL toggle_in_reset_assert got %b exp 1", soc_reset1);
        end
        halt_button = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step(1);
            checks++;
            if (soc_halt1 !== 1'b0) begin
                errors++;
                $display("FAIL toggle_in_reset edge %0d got %b exp 0", i, soc_halt1);
            end
        end
        reset_button = 1'b0;
        halt_button  = 1'b0;
        step(20);
        checks++;
        if (soc_halt1 !== 1'b0 || soc_reset1 !== 1'b0) begin
            errors++;
            $display("FAIL toggle_discarded got halt=%b reset=%b exp 0 0", soc_halt1, soc_reset1);
        end
    endtask

    task automatic test_mid_reset();
        apply_reset();
        halt_button = 1'b1;
        step(10);
        checks++;
        if (soc_halt0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_halt_up got %b exp 1", soc_halt0);
        end
        reset_button = 1'b1;
        step(10);
        reset_button = 1'b0;
        step(8);
        checks++;
        if (soc_reset0 !== 1'b1 || soc_halt0 !== 1'b1) begin
            errors++;
            $display("FAIL mid_in_hold got reset=%b halt=%b exp 1 1", soc_reset0, soc_halt0);
        end
        reset = 1'b1;
        step(1);
        checks++;
        if (soc_reset0 !== 1'b1 || soc_halt0 !== 1'b0 || soc_halt1 !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_edge got reset=%b halt0=%b halt1=%b exp 1 0 0",
                     soc_reset0, soc_halt0, soc_halt1);
        end
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            step(1);
            checks++;
            if (soc_reset0 !== (i < 8)) begin
                errors++;
                $display("FAIL mid_release edge %0d got %b exp %b", i, soc_reset0, (i < 8));
            end
            checks++;
            if (soc_halt0 !== (i >= 7) || soc_halt1 !== 1'b0) begin
                errors++;
                $display("FAIL mid_halt edge %0d got %b/%b exp %b/0",
                         i, soc_halt0, soc_halt1, (i >= 7));
            end
        end
        halt_button = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        reset_button = 1'b0;
        halt_button  = 1'b0;
        test_reset();
        test_glitch();
        test_reset_press();
        test_repress_hold();
        test_toggle();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
